// File: rtl/game_report_tx_if.sv
// rtl/game_report_tx_if.sv - report request / UART status bundle for game_report_tx
// Purpose: groups the report request and the serial/status outputs of game_report_tx.
// Signals:
//   send_trigger - one-cycle request to report value (master -> slave)
//   value[9:0]   - unsigned timer value to report   (master -> slave)
//   tx           - UART 8N1 line, idle high         (slave -> master)
//   busy         - report converting or in flight   (slave -> master)
//   done         - one-cycle pulse, frame left tx   (slave -> master)
interface game_report_tx_if;
  logic       send_trigger;
  logic [9:0] value;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output send_trigger,
    output value,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  send_trigger,
    input  value,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/game_report_tx.sv
// rtl/game_report_tx.sv - converts a 10-bit timer value to "T=ddd\r\n" and sends it over UART 8N1
// Purpose: on a trigger in IDLE, latch value (clamped to 999), convert it to three BCD
//          digits with 10 shift-add-3 steps, then send 7 bytes back-to-back on tx.
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - game_report_tx_if.slave: send_trigger, value in; tx, busy, done out
module game_report_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input logic            clk,
  input logic            reset_n,
  game_report_tx_if.slave bus
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;

  logic [1:0]       r_state;
  logic [9:0]       r_value;
  logic [11:0]      r_bcd;
  logic [3:0]       r_conv_cnt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [3:0]       r_bit_idx;
  logic [2:0]       r_byte_idx;
  logic             r_tx;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [9:0]       w_value_nxt;
  logic [11:0]      w_bcd_nxt;
  logic [3:0]       w_conv_cnt_nxt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [3:0]       w_bit_idx_nxt;
  logic [2:0]       w_byte_idx_nxt;
  logic             w_done_nxt;
  logic [7:0]       w_byte;
  logic             w_tx_nxt;

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dabble(input logic [11:0] bcd, input logic in_bit);
    logic [11:0] a;
    a = bcd;
    if (a[3:0]  >= 4'd5) a[3:0]  = a[3:0]  + 4'd3;
    if (a[7:4]  >= 4'd5) a[7:4]  = a[7:4]  + 4'd3;
    if (a[11:8] >= 4'd5) a[11:8] = a[11:8] + 4'd3;
    return {a[10:0], in_bit};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [11:0] bcd);
    case (idx)
      3'd0:    return 8'h54;
      3'd1:    return 8'h3D;
      3'd2:    return {4'h3, bcd[11:8]};
      3'd3:    return {4'h3, bcd[7:4]};
      3'd4:    return {4'h3, bcd[3:0]};
      3'd5:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_value_nxt    = r_value;
    w_bcd_nxt      = r_bcd;
    w_conv_cnt_nxt = r_conv_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.send_trigger) begin
          w_state_nxt    = S_CONVERT;
          w_value_nxt    = (bus.value > 10'd999) ? 10'd999 : bus.value;
          w_bcd_nxt      = '0;
          w_conv_cnt_nxt = '0;
        end
      end
      S_CONVERT: begin
        // Binary bits are consumed MSB first straight from the latched value,
        // so the latched copy itself never changes until the next trigger.
        w_bcd_nxt = dabble(r_bcd, r_value[4'd9 - r_conv_cnt]);
        if (r_conv_cnt == 4'd9) begin
          w_state_nxt    = S_SEND;
          w_conv_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
          w_bit_idx_nxt  = '0;
          w_byte_idx_nxt = '0;
        end else begin
          w_conv_cnt_nxt = r_conv_cnt + 4'd1;
        end
      end
      S_SEND: begin
        if (r_bit_cnt == CNT_LAST) begin
          w_bit_cnt_nxt = '0;
          if (r_bit_idx == 4'd9) begin
            w_bit_idx_nxt = '0;
            if (r_byte_idx == 3'd6) begin
              w_byte_idx_nxt = '0;
              w_state_nxt    = S_IDLE;
              w_done_nxt     = 1'b1;
            end else begin
              w_byte_idx_nxt = r_byte_idx + 3'd1;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_conv_cnt_nxt = '0;
        w_bit_cnt_nxt  = '0;
        w_bit_idx_nxt  = '0;
        w_byte_idx_nxt = '0;
      end
    endcase
  end

  // tx is registered from the next-state view so the line never glitches;
  // bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_comb begin
    w_byte   = frame_byte(w_byte_idx_nxt, w_bcd_nxt);
    w_tx_nxt = 1'b1;
    if (w_state_nxt == S_SEND) begin
      if (w_bit_idx_nxt == 4'd0)
        w_tx_nxt = 1'b0;
      else if (w_bit_idx_nxt <= 4'd8)
        w_tx_nxt = w_byte[3'(w_bit_idx_nxt - 4'd1)];
      else
        w_tx_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_value    <= '0;
      r_bcd      <= '0;
      r_conv_cnt <= '0;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_value    <= w_value_nxt;
      r_bcd      <= w_bcd_nxt;
      r_conv_cnt <= w_conv_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;

endmodule

// File: tb/tb_game_report_tx.sv
// tb/tb_game_report_tx.sv - directed self-checking bench for game_report_tx
module tb_game_report_tx;
  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  game_report_tx_if bus ();

  game_report_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic trigger(input logic [9:0] v);
    @(negedge clk);
    bus.send_trigger = 1'b1;
    bus.value        = v;
  endtask

  // Observes one report cycle-by-cycle starting on the negedge after the accepting edge:
  // 10 CONVERT cycles, then 70 bit windows of 10 cycles, then the done cycle.
  task automatic capture(input logic retrig, input logic [9:0] rv, input logic wiggle,
                         output logic [55:0] got, output int conv_low, output int busy_low,
                         output int early_done, output int frame_err,
                         output logic end_done, output logic end_busy);
    int s, b, c, byte_i, bit_i;
    logic first;
    got = '0; conv_low = 0; busy_low = 0; early_done = 0; frame_err = 0; first = 1'b1;
    for (int k = 1; k <= 710; k++) begin
      @(negedge clk);
      if (k == 1) bus.send_trigger = 1'b0;
      if (wiggle) bus.value = 10'($urandom);
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.done !== 1'b0) early_done++;
      if (k <= 10) begin
        if (bus.tx !== 1'b1) conv_low++;
      end else begin
        s = k - 11; b = s / 10; c = s % 10; byte_i = b / 10; bit_i = b % 10;
        if (c == 0) first = bus.tx;
        else if (bus.tx !== first) frame_err++;
        if (c == 5) begin
          if (bit_i == 0 && bus.tx !== 1'b0) frame_err++;
          else if (bit_i == 9 && bus.tx !== 1'b1) frame_err++;
          else if (bit_i >= 1 && bit_i <= 8) got[byte_i*8 + bit_i - 1] = bus.tx;
        end
      end
    end
    @(negedge clk);
    end_done = bus.done;
    end_busy = bus.busy;
    if (retrig) begin
      bus.send_trigger = 1'b1;
      bus.value        = rv;
    end
  endtask

  logic [55:0] got;
  int   conv_low, busy_low, early_done, frame_err;
  logic end_done, end_busy;

  task automatic test_reset();
    reset_n = 1'b0; bus.send_trigger = 1'b0; bus.value = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL reset_tx got %b want 1", bus.tx); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if ({bus.tx, bus.busy, bus.done} !== 3'b100) $display("FAIL idle_after_reset got %b want 100", {bus.tx, bus.busy, bus.done}); else n_pass++;
  endtask

  task automatic test_basic();
    trigger(10'd123);
    capture(1'b0, '0, 1'b0, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
    n_checks++; if (got !== 56'h0A0D3332313D54) $display("FAIL basic_bytes got %h want 0a0d3332313d54", got); else n_pass++;
    n_checks++; if (conv_low !== 0) $display("FAIL basic_convert_tx_low got %0d want 0", conv_low); else n_pass++;
    n_checks++; if (busy_low !== 0) $display("FAIL basic_busy_low got %0d want 0", busy_low); else n_pass++;
    n_checks++; if (frame_err !== 0) $display("FAIL basic_frame_timing got %0d want 0", frame_err); else n_pass++;
    n_checks++; if (early_done !== 0) $display("FAIL basic_early_done got %0d want 0", early_done); else n_pass++;
    n_checks++; if (end_done !== 1'b1) $display("FAIL basic_done got %b want 1", end_done); else n_pass++;
    n_checks++; if (end_busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", end_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) $display("FAIL basic_done_width got %b want 0", bus.done); else n_pass++;
  endtask

  task automatic test_leading_zero_and_clamp();
    trigger(10'd7);
    capture(1'b0, '0, 1'b0, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
    n_checks++; if (got !== 56'h0A0D3730303D54) $display("FAIL zero_pad_bytes got %h want 0a0d3730303d54", got); else n_pass++;
    n_checks++; if (frame_err !== 0 || end_done !== 1'b1) $display("FAIL zero_pad_frame got err=%0d done=%b want err=0 done=1", frame_err, end_done); else n_pass++;
    trigger(10'd1023);
    capture(1'b0, '0, 1'b0, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
    n_checks++; if (got !== 56'h0A0D3939393D54) $display("FAIL clamp_bytes got %h want 0a0d3939393d54", got); else n_pass++;
    n_checks++; if (frame_err !== 0 || end_done !== 1'b1) $display("FAIL clamp_frame got err=%0d done=%b want err=0 done=1", frame_err, end_done); else n_pass++;
  endtask

  task automatic test_ignore_retrigger();
    int extra_done, extra_busy;
    trigger(10'd864);
    fork
      capture(1'b0, '0, 1'b0, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
      begin
        repeat (300) @(negedge clk);
        bus.send_trigger = 1'b1; bus.value = 10'd500;
        @(negedge clk);
        bus.send_trigger = 1'b0;
      end
    join
    n_checks++; if (got !== 56'h0A0D3436383D54) $display("FAIL ignore_bytes got %h want 0a0d3436383d54", got); else n_pass++;
    n_checks++; if (frame_err !== 0 || early_done !== 0) $display("FAIL ignore_frame got err=%0d early_done=%0d want 0 0", frame_err, early_done); else n_pass++;
    n_checks++; if (end_done !== 1'b1) $display("FAIL ignore_done got %b want 1", end_done); else n_pass++;
    extra_done = 0; extra_busy = 0;
    repeat (800) begin
      @(negedge clk);
      if (bus.done !== 1'b0) extra_done++;
      if (bus.busy !== 1'b0) extra_busy++;
    end
    n_checks++; if (extra_done !== 0) $display("FAIL ignore_second_done got %0d want 0", extra_done); else n_pass++;
    n_checks++; if (extra_busy !== 0) $display("FAIL ignore_second_frame_busy got %0d want 0", extra_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    trigger(10'd321);
    capture(1'b1, 10'd42, 1'b0, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
    n_checks++; if (got !== 56'h0A0D3132333D54) $display("FAIL b2b_first_bytes got %h want 0a0d3132333d54", got); else n_pass++;
    n_checks++; if (end_done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", end_done); else n_pass++;
    capture(1'b0, '0, 1'b0, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
    n_checks++; if (got !== 56'h0A0D3234303D54) $display("FAIL b2b_second_bytes got %h want 0a0d3234303d54", got); else n_pass++;
    n_checks++; if (busy_low !== 0 || conv_low !== 0 || frame_err !== 0) $display("FAIL b2b_second_timing got busy_low=%0d conv_low=%0d err=%0d want 0 0 0", busy_low, conv_low, frame_err); else n_pass++;
    n_checks++; if (end_done !== 1'b1) $display("FAIL b2b_second_done got %b want 1", end_done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int done_seen, busy_seen, tx_low;
    trigger(10'd123);
    @(negedge clk);
    bus.send_trigger = 1'b0;
    // Lands on byte 3 ('2' = 0x32), first data bit, which is a 0 on the line.
    repeat (325) @(negedge clk);
    n_checks++; if ({bus.busy, bus.tx} !== 2'b10) $display("FAIL abort_inflight got busy,tx=%b want 10", {bus.busy, bus.tx}); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({bus.tx, bus.busy, bus.done} !== 3'b100) $display("FAIL abort_async got tx,busy,done=%b want 100", {bus.tx, bus.busy, bus.done}); else n_pass++;
    done_seen = 0; busy_seen = 0; tx_low = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
      if (bus.busy !== 1'b0) busy_seen++;
      if (bus.tx !== 1'b1) tx_low++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
      if (bus.busy !== 1'b0) busy_seen++;
      if (bus.tx !== 1'b1) tx_low++;
    end
    n_checks++; if (done_seen !== 0) $display("FAIL abort_no_done got %0d want 0", done_seen); else n_pass++;
    n_checks++; if (busy_seen !== 0 || tx_low !== 0) $display("FAIL abort_idle got busy=%0d tx_low=%0d want 0 0", busy_seen, tx_low); else n_pass++;
    trigger(10'd9);
    capture(1'b0, '0, 1'b0, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
    n_checks++; if (got !== 56'h0A0D3930303D54) $display("FAIL abort_fresh_bytes got %h want 0a0d3930303d54", got); else n_pass++;
    n_checks++; if (frame_err !== 0 || conv_low !== 0 || end_done !== 1'b1) $display("FAIL abort_fresh_frame got err=%0d conv_low=%0d done=%b want 0 0 1", frame_err, conv_low, end_done); else n_pass++;
  endtask

  task automatic test_value_change();
    trigger(10'd250);
    capture(1'b0, '0, 1'b1, got, conv_low, busy_low, early_done, frame_err, end_done, end_busy);
    n_checks++; if (got !== 56'h0A0D3035323D54) $display("FAIL stable_value_bytes got %h want 0a0d3035323d54", got); else n_pass++;
    n_checks++; if (frame_err !== 0 || end_done !== 1'b1) $display("FAIL stable_value_frame got err=%0d done=%b want 0 1", frame_err, end_done); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zero_and_clamp();
    test_ignore_retrigger();
    test_back_to_back();
    test_reset_abort();
    test_value_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
